// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator with colour re-alignment pipeline.
// Latency: coordinates 1 clock after counter; pins DRAW_LAT+1 clocks after coordinates.
// Backpressure: none; free-running raster, draw_* sampled unconditionally every clock.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1440,
    parameter int H_FP     = 80,
    parameter int H_SYNC   = 152,
    parameter int H_BP     = 232,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 28,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1,
    parameter int COLOR_W  = 4,
    parameter int DRAW_LAT = 0,
    localparam int X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [COLOR_W-1:0] i_draw_r,
    input  logic [COLOR_W-1:0] i_draw_g,
    input  logic [COLOR_W-1:0] i_draw_b,
    output logic [X_W-1:0]     o_curr_x,
    output logic [Y_W-1:0]     o_curr_y,
    output logic               o_coord_valid,
    output logic               o_frame_start,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [COLOR_W-1:0] o_pix_r,
    output logic [COLOR_W-1:0] o_pix_g,
    output logic [COLOR_W-1:0] o_pix_b
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One spare count of headroom so the active-end bound never aliases to 0
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] H_ACT_BEG  = HC_W'(H_SYNC + H_BP);
    localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_ACT_BEG  = VC_W'(V_SYNC + V_BP);
    localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [HC_W-1:0]    r_h_cnt;
    logic [VC_W-1:0]    r_v_cnt;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;

    logic [X_W-1:0]     r_curr_x;
    logic [Y_W-1:0]     r_curr_y;
    logic               r_coord_valid;
    logic               r_frame_start;
    logic               r_hs_raw;
    logic               r_vs_raw;

    logic [DRAW_LAT:0]  r_hs_sr;
    logic [DRAW_LAT:0]  r_vs_sr;
    logic [DRAW_LAT:0]  r_de_sr;
    logic [COLOR_W-1:0] r_draw_r;
    logic [COLOR_W-1:0] r_draw_g;
    logic [COLOR_W-1:0] r_draw_b;
    logic               w_de;

    // Position decode of the current counter state
    always_comb begin
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
        w_active = (r_h_cnt >= H_ACT_BEG) && (r_h_cnt < H_ACT_END) &&
                   (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
        w_hs_raw = (r_h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
        w_vs_raw = (r_v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
    end

    // Raster counters: h wraps every line, v advances only on the h wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HC_W'(1);
        end
    end

    // Coordinate stage: everything the draw logic sees, plus raw syncs kept in phase with it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_curr_x      <= '0;
            r_curr_y      <= '0;
            r_coord_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= ~HS_POL;
            r_vs_raw      <= ~VS_POL;
        end else begin
            r_curr_x      <= w_active ? X_W'(r_h_cnt - H_ACT_BEG) : '0;
            r_curr_y      <= w_active ? Y_W'(r_v_cnt - V_ACT_BEG) : '0;
            r_coord_valid <= w_active;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_hs_raw      <= w_hs_raw;
            r_vs_raw      <= w_vs_raw;
        end
    end

    // Delay syncs/DE by the draw latency plus the colour register so they meet the colour at the pins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hs_sr <= {(DRAW_LAT + 1){~HS_POL}};
            r_vs_sr <= {(DRAW_LAT + 1){~VS_POL}};
            r_de_sr <= '0;
        end else begin
            r_hs_sr[0] <= r_hs_raw;
            r_vs_sr[0] <= r_vs_raw;
            r_de_sr[0] <= r_coord_valid;
            for (int i = 1; i <= DRAW_LAT; i++) begin
                r_hs_sr[i] <= r_hs_sr[i-1];
                r_vs_sr[i] <= r_vs_sr[i-1];
                r_de_sr[i] <= r_de_sr[i-1];
            end
        end
    end

    // Single register on the returning colour
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_draw_r <= '0;
            r_draw_g <= '0;
            r_draw_b <= '0;
        end else begin
            r_draw_r <= i_draw_r;
            r_draw_g <= i_draw_g;
            r_draw_b <= i_draw_b;
        end
    end

    // Pin drive: colour blanked whenever the aligned DE is low
    always_comb begin
        w_de          = r_de_sr[DRAW_LAT];
        o_hsync       = r_hs_sr[DRAW_LAT];
        o_vsync       = r_vs_sr[DRAW_LAT];
        o_de          = w_de;
        o_pix_r       = w_de ? r_draw_r : '0;
        o_pix_g       = w_de ? r_draw_g : '0;
        o_pix_b       = w_de ? r_draw_b : '0;
        o_curr_x      = r_curr_x;
        o_curr_y      = r_curr_y;
        o_coord_valid = r_coord_valid;
        o_frame_start = r_frame_start;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int NCYC = 12000;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, lat;
    } cfg_t;

    typedef struct packed {
        logic [15:0] cx;
        logic [15:0] cy;
        logic        cv;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [3:0]  pr;
        logic [3:0]  pg;
        logic [3:0]  pb;
    } exp_t;

    typedef struct packed {
        exp_t e2;
        exp_t e1;
        exp_t e0;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [3:0] dr  [3];
    logic [3:0] dg  [3];
    logic [3:0] db  [3];

    logic [10:0] x0; logic [9:0] y0;
    logic [4:0]  x1; logic [3:0] y1;
    logic [1:0]  x2; logic [1:0] y2;
    logic        cv [3];
    logic        fs [3];
    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic [3:0]  pr [3];
    logic [3:0]  pg [3];
    logic [3:0]  pb [3];

    cfg_t cfg [3];
    int   n   [3];
    int   rst_at [3];
    exp_t cur [3];
    ent_t sb_q [$];
    event ev_chk;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Default 1440x900 timing, DRAW_LAT=0
    vga_timing_gen u0 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_draw_r(dr[0]), .i_draw_g(dg[0]), .i_draw_b(db[0]),
        .o_curr_x(x0), .o_curr_y(y0), .o_coord_valid(cv[0]), .o_frame_start(fs[0]),
        .o_hsync(hs[0]), .o_vsync(vs[0]), .o_de(de[0]),
        .o_pix_r(pr[0]), .o_pix_g(pg[0]), .o_pix_b(pb[0])
    );

    // Mid-size raster with a 3-clock drawing latency
    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(4), .DRAW_LAT(3)
    ) u1 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_draw_r(dr[1]), .i_draw_g(dg[1]), .i_draw_b(db[1]),
        .o_curr_x(x1), .o_curr_y(y1), .o_coord_valid(cv[1]), .o_frame_start(fs[1]),
        .o_hsync(hs[1]), .o_vsync(vs[1]), .o_de(de[1]),
        .o_pix_r(pr[1]), .o_pix_g(pg[1]), .o_pix_b(pb[1])
    );

    // Tiny raster with inverted sync polarities
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(4), .DRAW_LAT(0)
    ) u2 (
        .i_clk(clk), .i_rst(rst[2]),
        .i_draw_r(dr[2]), .i_draw_g(dg[2]), .i_draw_b(db[2]),
        .o_curr_x(x2), .o_curr_y(y2), .o_coord_valid(cv[2]), .o_frame_start(fs[2]),
        .o_hsync(hs[2]), .o_vsync(vs[2]), .o_de(de[2]),
        .o_pix_r(pr[2]), .o_pix_g(pg[2]), .o_pix_b(pb[2])
    );

    // Raster position of counter index p; returns whether it lies in the visible window
    function automatic bit pos_at(input cfg_t c, input int p, output int h, output int v);
        int ht;
        int vt;
        ht = c.hsw + c.hbp + c.ha + c.hfp;
        vt = c.vsw + c.vbp + c.va + c.vfp;
        h  = p % ht;
        v  = (p / ht) % vt;
        return (h >= c.hsw + c.hbp) && (h < c.hsw + c.hbp + c.ha) &&
               (v >= c.vsw + c.vbp) && (v < c.vsw + c.vbp + c.va);
    endfunction

    // Expected outputs after the n-th clock edge since reset release (n=0: in reset)
    function automatic exp_t model(input cfg_t c, input int n_edge, input logic [3:0] g, input logic [3:0] b);
        exp_t e;
        int   h;
        int   v;
        bit   a;
        e    = '0;
        e.hs = (c.hpol == 0);
        e.vs = (c.vpol == 0);
        if (n_edge >= 1) begin
            a    = pos_at(c, n_edge - 1, h, v);
            e.fs = (h == 0) && (v == 0);
            if (a) begin
                e.cv = 1'b1;
                e.cx = 16'(h - c.hsw - c.hbp);
                e.cy = 16'(v - c.vsw - c.vbp);
            end
        end
        if (n_edge - 2 - c.lat >= 0) begin
            a    = pos_at(c, n_edge - 2 - c.lat, h, v);
            e.hs = (h < c.hsw) ? (c.hpol != 0) : (c.hpol == 0);
            e.vs = (v < c.vsw) ? (c.vpol != 0) : (c.vpol == 0);
            if (a) begin
                e.de = 1'b1;
                e.pr = 4'(h - c.hsw - c.hbp);
                e.pg = g;
                e.pb = b;
            end
        end
        return e;
    endfunction

    function automatic exp_t act_of(input int i);
        exp_t a;
        a = '0;
        case (i)
            0: begin a.cx = 16'(x0); a.cy = 16'(y0); end
            1: begin a.cx = 16'(x1); a.cy = 16'(y1); end
            default: begin a.cx = 16'(x2); a.cy = 16'(y2); end
        endcase
        a.cv = cv[i]; a.fs = fs[i]; a.hs = hs[i]; a.vs = vs[i]; a.de = de[i];
        a.pr = pr[i]; a.pg = pg[i]; a.pb = pb[i];
        return a;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s u%0d t=%0t got=%0d want=%0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic cmp(input int i, input exp_t e);
        exp_t a;
        a = act_of(i);
        chk("curr_x", i, int'(a.cx), int'(e.cx));
        chk("curr_y", i, int'(a.cy), int'(e.cy));
        chk("coord_valid", i, int'(a.cv), int'(e.cv));
        chk("frame_start", i, int'(a.fs), int'(e.fs));
        chk("hsync", i, int'(a.hs), int'(e.hs));
        chk("vsync", i, int'(a.vs), int'(e.vs));
        chk("de", i, int'(a.de), int'(e.de));
        chk("pix_r", i, int'(a.pr), int'(e.pr));
        chk("pix_g", i, int'(a.pg), int'(e.pg));
        chk("pix_b", i, int'(a.pb), int'(e.pb));
    endtask

    // Monitor: drains the scoreboard each time the outputs are due for sampling
    initial begin
        ent_t ent;
        forever begin
            @(ev_chk);
            while (sb_q.size() > 0) begin
                ent = sb_q.pop_front();
                cmp(0, ent.e0);
                cmp(1, ent.e1);
                cmp(2, ent.e2);
            end
            if (n_err > 200) begin
                $display("Result: errors=%0d of %0d checks", n_err, n_chk);
                $finish;
            end
        end
    end

    task automatic push_cur();
        ent_t ent;
        ent.e0 = cur[0];
        ent.e1 = cur[1];
        ent.e2 = cur[2];
        sb_q.push_back(ent);
    endtask

    // Stimulus: reset sequencing, drawing-logic model and expected-value generation
    initial begin
        int idx;
        int h;
        int v;
        cfg[0] = '{1440, 80, 152, 232, 900, 1, 3, 28, 0, 1, 0};
        cfg[1] = '{20, 3, 4, 5, 10, 2, 2, 3, 0, 1, 3};
        cfg[2] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0};
        rst_at[0] = 9000;
        rst_at[1] = 4000 + $urandom_range(0, 543);
        rst_at[2] = 3000 + $urandom_range(0, 47);
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            n[i]   = 0;
            dr[i]  = 4'hF;
            dg[i]  = 4'hF;
            db[i]  = 4'hF;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst[i]) n[i]++;
                cur[i] = model(cfg[i], n[i], dg[i], db[i]);
            end
            push_cur();
            @(negedge clk);
            ->ev_chk;
            for (int i = 0; i < 3; i++) begin
                if (cyc == 5 || (cyc == rst_at[i] + 2)) rst[i] = 1'b0;
                if (rst[i]) begin
                    dr[i] = 4'hF;
                    dg[i] = 4'hF;
                    db[i] = 4'hF;
                end else begin
                    dr[i] = 4'($urandom);
                    dg[i] = 4'($urandom);
                    db[i] = 4'($urandom);
                    idx   = n[i] - cfg[i].lat - 1;
                    if (idx >= 0 && pos_at(cfg[i], idx, h, v))
                        dr[i] = 4'(h - cfg[i].hsw - cfg[i].hbp);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (cyc == rst_at[i]) begin
                    #2;
                    rst[i] = 1'b1;
                    n[i]   = 0;
                    #1;
                    cur[i] = model(cfg[i], 0, dg[i], db[i]);
                    push_cur();
                    ->ev_chk;
                end
            end
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
